// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - byte-addressed instruction memory with fixed-latency fetch handshake
module instr_mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [31:0]           readdata,
  output logic                  busywait,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [7:0]            load_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT = READ_LATENCY[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              counter;
  logic [ADDR_WIDTH-3:0]   word_addr;
  logic [7:0]              mem [0:DEPTH-1];
  logic [31:0]             word;

  // Byte-offset bits of the PC are dropped: fetches are always word aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[1:0];

  // Program store; not touched by RESET so a loaded image survives a mid-run reset.
  always_ff @(posedge CLK) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Big-endian word assembly from the latched word address; reads the pre-edge array contents.
  always_comb begin
    word = {mem[{word_addr, 2'b00}],
            mem[{word_addr, 2'b01}],
            mem[{word_addr, 2'b10}],
            mem[{word_addr, 2'b11}]};
  end

  // Fetch sequencer: accept in IDLE, count latency in BUSY, present the word for one DONE cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      counter  <= 4'd0;
      readdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (read) begin
            word_addr <= address[ADDR_WIDTH-1:2];
            counter   <= 4'd1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (counter == LAT) begin
            readdata <= word;
            state    <= DONE;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall is combinational in IDLE so the CPU freezes in the same cycle it raises read.
  always_comb begin
    busywait = 1'b0;
    if (!RESET) begin
      case (state)
        IDLE:    busywait = read;
        BUSY:    busywait = 1'b1;
        default: busywait = 1'b0;
      endcase
    end
  end

endmodule
